dffbank_ctrl: RTL

//  Controller for a bank of NCELL D flip-flop cells with set/clear.
//  Two requesters share the bank; an arbiter selects one requester per transaction.
//  The selected op is applied as one cell-level strobe (load D, set or clear).
//  A single-cycle ack closes the transaction.

---
 rtl/dffbank_pkg.sv | 17 +
 rtl/dffbank_if.sv | 30 +++
 rtl/dffbank_cell.sv | 26 ++
 rtl/dffbank_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/dffbank_pkg.sv
// Shared types for the flip-flop bank controller: cell op encodings and FSM states.
package dffbank_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLR   = 2'b10,
    OP_READ  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    ACK
  } state_e;

endpackage

// File: rtl/dffbank_if.sv
// Two-requester access bus for the flip-flop bank, plus the observable cell outputs.
interface dffbank_if #(
  parameter int unsigned NCELL = 8,
  parameter int unsigned AW    = 3
);
  logic             req0;
  logic [1:0]       op0;
  logic [AW-1:0]    addr0;
  logic             din0;
  logic             ack0;
  logic             req1;
  logic [1:0]       op1;
  logic [AW-1:0]    addr1;
  logic             din1;
  logic             ack1;
  logic             rdata;
  logic             err;
  logic [NCELL-1:0] q;
  logic [NCELL-1:0] qn;

  modport master (
    output req0, op0, addr0, din0, req1, op1, addr1, din1,
    input  ack0, ack1, rdata, err, q, qn
  );

  modport slave (
    input  req0, op0, addr0, din0, req1, op1, addr1, din1,
    output ack0, ack1, rdata, err, q, qn
  );
endinterface

// File: rtl/dffbank_cell.sv
// Single D flip-flop cell with synchronous reset, set, clear and load (in that priority).
module dffbank_cell (
  input  logic clk_i,
  input  logic rst_i,
  input  logic set_i,
  input  logic clr_i,
  input  logic load_i,
  input  logic d_i,
  output logic q_o
);
  logic q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= 1'b0;
    end else if (set_i) begin
      q_q <= 1'b1;
    end else if (clr_i) begin
      q_q <= 1'b0;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/dffbank_ctrl.sv
// Arbitrated controller for a bank of NCELL flip-flop cells: IDLE -> APPLY -> ACK per transaction.
// Define DFFBANK_FIXPRI_EN for fixed priority (requester 0 wins ties); default is round-robin.
module dffbank_ctrl
  import dffbank_pkg::*;
#(
  parameter int unsigned NCELL = 8,
  parameter int unsigned AW    = 3
) (
  input logic      clk,
  input logic      r,
  dffbank_if.slave bus
);
  state_e           state_q;
  op_e              op_q;
  logic [AW-1:0]    addr_q;
  logic             din_q;
  logic             gnt_q;
  logic             ack0_q;
  logic             ack1_q;
  logic             rdata_q;
  logic             err_q;
  logic             grant1;
  logic             in_range;
  logic             cur_bit;
  logic             post_bit;
  logic [NCELL-1:0] q;
  logic [NCELL-1:0] set_v;
  logic [NCELL-1:0] clr_v;
  logic [NCELL-1:0] load_v;

`ifdef DFFBANK_FIXPRI_EN
  assign grant1 = bus.req1 & ~bus.req0;
`else
  logic rr_q;  // 1: requester 1 wins the next tie
  assign grant1 = bus.req1 & (~bus.req0 | rr_q);
`endif

  assign in_range = 32'(addr_q) < NCELL;

  always_comb begin
    cur_bit = 1'b0;
    for (int unsigned i = 0; i < NCELL; i++) begin
      if (addr_q == AW'(i)) cur_bit = q[i];
    end
  end

  // Value the addressed cell holds once APPLY completes, so rdata is registered with it.
  always_comb begin
    post_bit = cur_bit;
    case (op_q)
      OP_WRITE: post_bit = din_q;
      OP_SET:   post_bit = 1'b1;
      OP_CLR:   post_bit = 1'b0;
      default:  post_bit = cur_bit;
    endcase
  end

  for (genvar i = 0; i < NCELL; i++) begin : g_cell
    logic hit;
    assign hit       = (state_q == APPLY) && in_range && (addr_q == AW'(i));
    assign load_v[i] = hit && (op_q == OP_WRITE);
    assign set_v[i]  = hit && (op_q == OP_SET);
    assign clr_v[i]  = hit && (op_q == OP_CLR);

    dffbank_cell u_cell (
      .clk_i  (clk),
      .rst_i  (r),
      .set_i  (set_v[i]),
      .clr_i  (clr_v[i]),
      .load_i (load_v[i]),
      .d_i    (din_q),
      .q_o    (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= IDLE;
      op_q    <= OP_WRITE;
      addr_q  <= '0;
      din_q   <= 1'b0;
      gnt_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= 1'b0;
      err_q   <= 1'b0;
`ifndef DFFBANK_FIXPRI_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req0 | bus.req1) begin
            gnt_q   <= grant1;
            op_q    <= op_e'(grant1 ? bus.op1 : bus.op0);
            addr_q  <= grant1 ? bus.addr1 : bus.addr0;
            din_q   <= grant1 ? bus.din1 : bus.din0;
`ifndef DFFBANK_FIXPRI_EN
            rr_q    <= ~grant1;
`endif
            state_q <= APPLY;
          end
        end
        APPLY: begin
          rdata_q <= in_range & post_bit;
          err_q   <= ~in_range;
          ack0_q  <= ~gnt_q;
          ack1_q  <= gnt_q;
          state_q <= ACK;
        end
        ACK: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.q     = q;
  assign bus.qn    = ~q;
endmodule
